// File: rtl/mat_stream_sched_if.sv
// Bus bundle for mat_stream_sched: the flat-matrix input stream and the element output stream.
// The "slave" modport is the scheduler's view; "master" is the producer/consumer environment.
interface mat_stream_sched_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IW    = (N > 1) ? $clog2(N) : 1
);
    logic                   s_valid;
    logic                   s_ready;
    logic [N*N*WIDTH-1:0]   s_data;
    logic                   s_transpose;
    logic                   m_valid;
    logic                   m_ready;
    logic [WIDTH-1:0]       m_data;
    logic [IW-1:0]          m_row;
    logic [IW-1:0]          m_col;
    logic                   m_last_line;
    logic                   m_last;

    modport slave (
        input  s_valid, s_data, s_transpose, m_ready,
        output s_ready, m_valid, m_data, m_row, m_col, m_last_line, m_last
    );

    modport master (
        output s_valid, s_data, s_transpose, m_ready,
        input  s_ready, m_valid, m_data, m_row, m_col, m_last_line, m_last
    );
endinterface

// File: rtl/mat_stream_sched.sv
// Streams one buffered N x N matrix out element by element, row-major or column-major,
// and reloads on the final beat so consecutive matrices flow with no idle cycle.
module mat_stream_sched #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    mat_stream_sched_if.slave io,
    output logic              busy
);
    localparam int            AW       = (N > 1) ? $clog2(N * N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                         r_state;
    logic [N*N-1:0][WIDTH-1:0]      r_buf;
    logic                           r_transpose;
    logic [IW-1:0]                  r_outer;
    logic [IW-1:0]                  r_inner;

    logic                           w_streaming;
    logic                           w_inner_last;
    logic                           w_last;
    logic                           w_s_ready;
    logic                           w_load;
    logic [IW-1:0]                  w_row;
    logic [IW-1:0]                  w_col;
    logic [AW-1:0]                  w_elem;

    assign w_streaming  = (r_state == S_STREAM);
    assign w_inner_last = (r_inner == LAST_IDX);
    assign w_last       = w_inner_last && (r_outer == LAST_IDX);

    // Reload is allowed on the final accepted beat, so s_ready depends combinationally on m_ready.
    assign w_s_ready = rstn && (!w_streaming || (w_last && io.m_ready));
    assign w_load    = io.s_valid && w_s_ready;

    assign w_row  = r_transpose ? r_inner : r_outer;
    assign w_col  = r_transpose ? r_outer : r_inner;
    assign w_elem = AW'(w_row) * AW'(N) + AW'(w_col);

    assign io.s_ready     = w_s_ready;
    assign io.m_valid     = w_streaming;
    assign io.m_data      = r_buf[w_elem];
    assign io.m_row       = w_row;
    assign io.m_col       = w_col;
    assign io.m_last_line = w_streaming && w_inner_last;
    assign io.m_last      = w_streaming && w_last;
    assign busy           = w_streaming;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            // NOTE: the matrix buffer is reset too, so m_data reads 0 during and after reset.
            r_buf       <= '0;
            r_transpose <= 1'b0;
            r_outer     <= '0;
            r_inner     <= '0;
        end else begin
            if (w_load) begin
                r_buf       <= io.s_data;
                r_transpose <= io.s_transpose;
            end
            case (r_state)
                S_IDLE: begin
                    r_outer <= '0;
                    r_inner <= '0;
                    if (w_load) r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (io.m_ready) begin
                        if (w_last) begin
                            r_outer <= '0;
                            r_inner <= '0;
                            if (!io.s_valid) r_state <= S_IDLE;
                        end else if (w_inner_last) begin
                            r_inner <= '0;
                            r_outer <= r_outer + 1'b1;
                        end else begin
                            r_inner <= r_inner + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_stream_sched.sv
// Directed bench for mat_stream_sched (N=4, WIDTH=8): reset, row/column order, stalls,
// back-to-back matrices and a mid-stream reset, checked against a small index model.
module tb_mat_stream_sched;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int IW    = 2;
    localparam int NN    = N * N;

    logic clk = 1'b0;
    logic rstn;
    logic busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mat_stream_sched_if #(.N(N), .WIDTH(WIDTH), .IW(IW)) bus ();

    mat_stream_sched #(.N(N), .WIDTH(WIDTH), .IW(IW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus.slave),
        .busy (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Element (r,c) of matrix "base" is base + 10r + c.
    function automatic logic [N*N*WIDTH-1:0] mat(input int base);
        logic [N*N*WIDTH-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*WIDTH +: WIDTH] = WIDTH'(base + 10*r + c);
        return m;
    endfunction

    task automatic offer(input int base, input bit tp, input string name);
        @(negedge clk);
        bus.s_valid     = 1'b1;
        bus.s_data      = mat(base);
        bus.s_transpose = tp;
        bus.m_ready     = 1'b1;
        #1;
        check($sformatf("%s accept s_ready", name), 32'(bus.s_ready), 32'(1));
        check($sformatf("%s accept m_valid", name), 32'(bus.m_valid), 32'(0));
    endtask

    // Consume up to stop_after beats, checking every valid cycle against the model.
    task automatic consume(input bit tp, input int base, input bit rnd, input bit hold_sv,
                           input logic [N*N*WIDTH-1:0] nxt, input int stop_after,
                           input string name);
        int k;
        int cyc;
        int o, i, r, c;
        bit rdy;
        k   = 0;
        cyc = 0;
        while (k < stop_after && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (hold_sv) begin
                bus.s_data      = nxt;
                bus.s_transpose = 1'b0;
            end else begin
                bus.s_valid = 1'b0;
            end
            rdy         = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.m_ready = rdy;
            #1;
            o = k / N;
            i = k % N;
            r = tp ? i : o;
            c = tp ? o : i;
            check($sformatf("%s b%0d m_valid", name, k), 32'(bus.m_valid), 32'(1));
            check($sformatf("%s b%0d busy", name, k), 32'(busy), 32'(1));
            check($sformatf("%s b%0d data", name, k), 32'(bus.m_data), 32'(base + 10*r + c));
            check($sformatf("%s b%0d row", name, k), 32'(bus.m_row), 32'(r));
            check($sformatf("%s b%0d col", name, k), 32'(bus.m_col), 32'(c));
            check($sformatf("%s b%0d last_line", name, k), 32'(bus.m_last_line), 32'(i == N-1));
            check($sformatf("%s b%0d last", name, k), 32'(bus.m_last), 32'(k == NN-1));
            check($sformatf("%s b%0d s_ready", name, k), 32'(bus.s_ready),
                  32'((k == NN-1) && rdy));
            if (rdy) k++;
        end
        if (k < stop_after)
            check($sformatf("%s beat budget", name), 32'(k), 32'(stop_after));
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        bus.s_valid = 1'b0;
        #1;
        check($sformatf("%s idle m_valid", name), 32'(bus.m_valid), 32'(0));
        check($sformatf("%s idle busy", name), 32'(busy), 32'(0));
        check($sformatf("%s idle s_ready", name), 32'(bus.s_ready), 32'(1));
    endtask

    initial begin
        // Reset: all outputs low while asserted, ready once released, no beats appear.
        rstn            = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_transpose = 1'b0;
        bus.m_ready     = 1'b0;
        #2;
        check("reset m_valid", 32'(bus.m_valid), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset m_last", 32'(bus.m_last), 32'(0));
        check("reset m_last_line", 32'(bus.m_last_line), 32'(0));
        check("reset s_ready", 32'(bus.s_ready), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check("post-reset m_valid", 32'(bus.m_valid), 32'(0));
            check("post-reset s_ready", 32'(bus.s_ready), 32'(1));
        end

        // Row-major, full-rate consumer.
        offer(0, 1'b0, "rowmaj");
        consume(1'b0, 0, 1'b0, 1'b0, '0, NN, "rowmaj");
        expect_idle("rowmaj");

        // Column-major.
        offer(0, 1'b1, "colmaj");
        consume(1'b1, 0, 1'b0, 1'b0, '0, NN, "colmaj");
        expect_idle("colmaj");

        // Random back-pressure: outputs must hold the current beat while stalled.
        offer(0, 1'b0, "stall");
        consume(1'b0, 0, 1'b1, 1'b0, '0, NN, "stall");
        expect_idle("stall");

        // Back-to-back: s_valid held high, second matrix loads on the last beat.
        offer(0, 1'b0, "b2b first");
        consume(1'b0, 0, 1'b0, 1'b1, mat(100), NN, "b2b first");
        consume(1'b0, 100, 1'b0, 1'b0, '0, NN, "b2b second");
        expect_idle("b2b");

        // Mid-matrix reset after 7 beats.
        offer(0, 1'b0, "midrst");
        consume(1'b0, 0, 1'b0, 1'b0, '0, 7, "midrst");
        @(negedge clk);
        bus.m_ready = 1'b0;
        #1;
        check("midrst held row", 32'(bus.m_row), 32'(1));
        check("midrst held col", 32'(bus.m_col), 32'(3));
        rstn = 1'b0;
        #1;
        check("midrst m_valid", 32'(bus.m_valid), 32'(0));
        check("midrst m_last", 32'(bus.m_last), 32'(0));
        check("midrst busy", 32'(busy), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        offer(50, 1'b0, "after rst");
        consume(1'b0, 50, 1'b0, 1'b0, '0, NN, "after rst");
        expect_idle("after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
